noc_out_scheduler: RTL and testbench
====================================

# noc_out_scheduler

Per-output-port scheduler for the NoC router: arbitrates the five input ports (N, E, S, W, Local) onto one output link with round-robin fairness. It holds a grant for the whole packet (head flit to tail flit) and gates transmission on downstream buffer credits. It replaces the simple `busy` back-pressure at each router output with credit-based flow control and wormhole packet locking.

## Interface
- `DATA_WIDTH`, 288: flit width.
- `CREDITS`, 4: downstream buffer depth in flits; valid range 1..15.
- `CNT_W`, `$clog2(CREDITS+1)`: credit counter width (derived).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_flits`  in  [4:0][DATA_WIDTH-1:0]  candidate flit per input port, index 0=N, 1=E, 2=S, 3=W, 4=Local.
- `in_valid`  in  5  flit present at the input port.
- `in_last`  in  5  the presented flit is a packet tail; single-flit packets set it on the head.
- `in_pop`  out  5  one-hot, registered; the input's flit was taken this cycle.
- `out_flit`  out  DATA_WIDTH  registered output flit.
- `out_valid`  out  1  `out_flit` is valid for exactly this cycle.
- `credit_return`  in  1  downstream freed one buffer slot; at most one per cycle.
- `credits`  out  CNT_W  current credit count.
- `locked`  out  1  a packet is in flight.
- `lock_owner`  out  3  input index holding the lock; 0 when unlocked.
- `credit_err`  out  1  sticky; a credit was returned while the counter was already full.

## Operation
- Eligible set: `E = in_valid & ~in_pop`. A port popped last cycle is masked so the same flit is never sent twice.
- `send` is asserted in the current cycle iff `credits != 0` and:
  - IDLE: `E != 0`.
  - LOCKED: `E[owner]` is set.
- IDLE state:
  - The winner is the first set bit of E, scanning from `rr_ptr` upward mod 5.
  - On send with the winner's `in_last=1`: stay IDLE and set `rr_ptr <= (winner+1)%5`.
  - On send with `in_last=0`: go to LOCKED and set `owner <= winner`.
- LOCKED state:
  - Only `owner` is considered; all other inputs are ignored even when valid.
  - On send with `in_last[owner]=1`: go to IDLE and set `rr_ptr <= (owner+1)%5`.
  - `rr_ptr` is held while LOCKED.
- On send:
  - `out_flit <= in_flits[w]`, `out_valid <= 1`, `in_pop <= onehot(w)`.
  - Otherwise `out_valid <= 0` and `in_pop <= 0`; `out_flit` holds its last value.
- Credit counter:
  - `send` only: decrement by 1.
  - `credit_return` only: increment by 1.
  - Both in the same cycle: unchanged.
  - `credit_return` with the counter at `CREDITS` and no send: counter stays at `CREDITS` and `credit_err <= 1`.
- Reset values: IDLE, `rr_ptr=0`, `credits=CREDITS`, `out_flit=0`, `out_valid=0`, `in_pop=0`, `locked=0`, `lock_owner=0`, `credit_err=0`.
- Reset asserted mid-packet aborts the lock immediately. There is no tail recovery; upstream is reset together with this block.

## Timing
- Arbitration is combinational on cycle N inputs. `out_flit`, `out_valid` and `in_pop` are asserted in cycle N+1 for one cycle.
- Upstream must retire or advance its flit on the clock edge that ends a cycle with `in_pop` high. The masked input becomes eligible again in N+2.
- Per-input throughput is 1 flit / 2 cycles. Aggregate output throughput is 1 flit/cycle when two or more inputs alternate in IDLE; a single-owner locked packet runs at 1 flit / 2 cycles.
- A `credit_return` in cycle N is usable for a send decision in N+1, never in the same cycle. With `credits=0`, the earliest send is the cycle after the return.
- `locked` and `lock_owner` update on the same edge as `out_valid` for the head flit.
- `locked` drops on the edge that registers the tail.

## Structure
- Shared package `noc_pkg`: port index constants (`PORT_N=0`, `PORT_E=1`, `PORT_S=2`, `PORT_W=3`, `PORT_L=4`), `NUM_PORTS=5`, default `FLIT_W=288`, state enum `{SCH_IDLE, SCH_LOCKED}`.
- One sub-module `rr_pick5`: combinational rotating-priority picker, inputs `req[4:0]`, `ptr[2:0]`, outputs one-hot `gnt[4:0]` and `idx[2:0]`. It is reused by other router arbiters.

## Test plan
- Single-flit packets valid on all 5 inputs, credits ample, `rr_ptr=0` -> pops in order 0,1,2,3,4,0,…; `out_valid` high every cycle; `out_flit` matches the source data.
- 3-flit packet on input 2 (tail on the third flit) while input 0 is valid throughout -> `lock_owner=2` and three flits from input 2 at 2-cycle spacing; input 0 is granted only after the tail.
- `CREDITS=4`, `credit_return=0`, continuous traffic -> exactly 4 sends, then `credits=0` and `out_valid=0`. One `credit_return` pulse -> exactly one more send, starting the cycle after the pulse.
- `send` and `credit_return` in the same cycle with `credits=2` -> `credits` stays 2.
- `credit_return` with `credits=4` and idle -> `credits` stays 4, `credit_err=1` and it remains 1 until reset.
- `rst_n` asserted low mid-packet (`locked=1`) -> all outputs go to their reset values asynchronously; after release, arbitration restarts IDLE with `rr_ptr=0` and `credits=CREDITS`.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, flit width, scheduler state
// and the mod-5 port arithmetic helpers used by the arbiters.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 288;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic [0:0] {
        SCH_IDLE   = 1'b0,
        SCH_LOCKED = 1'b1
    } sch_state_e;

    // (p + k) mod 5 for p, k in 0..4
    function automatic logic [2:0] port_add(input logic [2:0] p, input logic [2:0] k);
        logic [3:0] sum;
        sum = {1'b0, p} + {1'b0, k};
        return (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
    endfunction

    // Out-of-range indices map to an empty vector
    function automatic logic [4:0] port_onehot(input logic [2:0] p);
        return 5'(5'd1 << p);
    endfunction

endpackage

// File: rtl/noc_out_scheduler_if.sv
// Bundle between the five input buffers, one output link and its credit return.
interface noc_out_scheduler_if #(
    parameter int DATA_WIDTH = noc_pkg::FLIT_W,
    parameter int CREDITS    = 4
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [4:0][DATA_WIDTH-1:0] in_flits;
    logic [4:0]                 in_valid;
    logic [4:0]                 in_last;
    logic [4:0]                 in_pop;
    logic [DATA_WIDTH-1:0]      out_flit;
    logic                       out_valid;
    logic                       credit_return;
    logic [CNT_W-1:0]           credits;
    logic                       locked;
    logic [2:0]                 lock_owner;
    logic                       credit_err;

    modport master (
        output in_flits, in_valid, in_last, credit_return,
        input  in_pop, out_flit, out_valid, credits, locked, lock_owner, credit_err
    );

    modport slave (
        input  in_flits, in_valid, in_last, credit_return,
        output in_pop, out_flit, out_valid, credits, locked, lock_owner, credit_err
    );

endinterface

// File: rtl/rr_pick5.sv
// Rotating-priority picker over five requesters: first set bit of req scanning
// upward from ptr, wrapping mod 5.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt,
    output logic [2:0] idx
);

    logic [2:0] base_s;
    logic [2:0] cand_s;
    logic       found_s;

    // Scan five positions starting at ptr; an illegal ptr falls back to port 0
    always_comb begin
        gnt     = 5'd0;
        idx     = 3'd0;
        found_s = 1'b0;
        cand_s  = 3'd0;
        base_s  = (ptr < 3'(NUM_PORTS)) ? ptr : PORT_N;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = port_add(base_s, 3'(i));
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        gnt = found_s ? port_onehot(idx) : 5'd0;
    end

endmodule

// File: rtl/noc_out_scheduler.sv
// Output-port scheduler: round-robin over five inputs, wormhole lock from head
// to tail flit, and credit-based flow control toward the downstream buffer.
module noc_out_scheduler
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int CREDITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_out_scheduler_if.slave   bus
);

    localparam int CNT_W = $clog2(CREDITS + 1);

    sch_state_e            state_r;
    logic [2:0]            rr_ptr_r;
    logic [2:0]            owner_r;
    logic [CNT_W-1:0]      credits_r;
    logic                  credit_err_r;
    logic [DATA_WIDTH-1:0] out_flit_r;
    logic                  out_valid_r;
    logic [4:0]            in_pop_r;

    logic [4:0]            eligible_s;
    logic [4:0]            pick_gnt_s;
    logic [2:0]            pick_idx_s;
    logic [4:0]            win_onehot_s;
    logic [2:0]            win_idx_s;
    logic                  win_last_s;
    logic                  has_credit_s;
    logic                  send_s;

    rr_pick5 u_pick (
        .req (eligible_s),
        .ptr (rr_ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Send decision; the port popped last cycle still shows its old flit, so it is masked
    always_comb begin
        eligible_s   = bus.in_valid & ~in_pop_r;
        has_credit_s = (credits_r != {CNT_W{1'b0}});
        case (state_r)
            SCH_IDLE: begin
                send_s       = has_credit_s & (|eligible_s);
                win_idx_s    = pick_idx_s;
                win_onehot_s = pick_gnt_s;
            end
            SCH_LOCKED: begin
                send_s       = has_credit_s & eligible_s[owner_r];
                win_idx_s    = owner_r;
                win_onehot_s = port_onehot(owner_r);
            end
            default: begin
                send_s       = 1'b0;
                win_idx_s    = PORT_N;
                win_onehot_s = 5'd0;
            end
        endcase
        win_last_s = bus.in_last[win_idx_s];
    end

    // Packet lock and round-robin pointer; the pointer only advances past a tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= SCH_IDLE;
            rr_ptr_r <= PORT_N;
            owner_r  <= PORT_N;
        end else if (send_s) begin
            case (state_r)
                SCH_IDLE: begin
                    if (win_last_s) begin
                        rr_ptr_r <= port_add(win_idx_s, 3'd1);
                    end else begin
                        state_r <= SCH_LOCKED;
                        owner_r <= win_idx_s;
                    end
                end
                SCH_LOCKED: begin
                    if (win_last_s) begin
                        state_r  <= SCH_IDLE;
                        owner_r  <= PORT_N;
                        rr_ptr_r <= port_add(owner_r, 3'd1);
                    end
                end
                default: begin
                    state_r <= SCH_IDLE;
                    owner_r <= PORT_N;
                end
            endcase
        end
    end

    // Output flit register and pop strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_pop_r    <= 5'd0;
        end else begin
            out_valid_r <= send_s;
            in_pop_r    <= send_s ? win_onehot_s : 5'd0;
            if (send_s) begin
                out_flit_r <= bus.in_flits[win_idx_s];
            end
        end
    end

    // Credit counter; a return at full is an upstream protocol error, not a wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_r    <= CNT_W'(CREDITS);
            credit_err_r <= 1'b0;
        end else begin
            case ({send_s, bus.credit_return})
                2'b10: credits_r <= credits_r - CNT_W'(1);
                2'b01: begin
                    if (credits_r == CNT_W'(CREDITS)) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credits_r <= credits_r + CNT_W'(1);
                    end
                end
                default: credits_r <= credits_r;
            endcase
        end
    end

    assign bus.in_pop     = in_pop_r;
    assign bus.out_flit   = out_flit_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.credits    = credits_r;
    assign bus.locked     = (state_r == SCH_LOCKED);
    assign bus.lock_owner = owner_r;
    assign bus.credit_err = credit_err_r;

endmodule

// File: tb/tb_noc_out_scheduler.sv
// Scoreboard bench for noc_out_scheduler: per-port upstream queues feed the
// DUT, expected output flits are queued in arbitration order and compared.
module tb_noc_out_scheduler;

    localparam int DW = 288;
    localparam int CR = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    noc_out_scheduler_if #(.DATA_WIDTH(DW), .CREDITS(CR)) bus ();

    noc_out_scheduler #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    pop;
        logic          lk;
        logic [2:0]    own;
        int            gap;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] qd[5][$];
    logic          ql[5][$];

    int         n_checks = 0;
    int         n_pass = 0;
    int         tick_no = 0;
    int         last_out_tick = 0;
    int         pulse_tick = 0;
    logic [4:0] pop_seen = 5'd0;
    logic       prev_ov = 1'b0;
    logic       cr_req = 1'b0;
    logic       auto_ret = 1'b0;

    task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_flit();
        logic [DW-1:0] f;
        for (int k = 0; k < DW / 32; k++) f[k*32 +: 32] = $urandom();
        return f;
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input int port, input logic lk,
                            input logic [2:0] own, input int gap);
        exp_t e;
        e.data = d;
        e.pop  = 5'(5'd1 << port);
        e.lk   = lk;
        e.own  = own;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic add_flit(input int port, input logic last, input logic push, input logic lk,
                            input logic [2:0] own, input int gap, output logic [DW-1:0] d);
        d = rand_flit();
        qd[port].push_back(d);
        ql[port].push_back(last);
        if (push) push_exp(d, port, lk, own, gap);
    endtask

    task automatic drive_inputs();
        logic [4:0][DW-1:0] f;
        logic [4:0]         v;
        logic [4:0]         l;
        f = '0;
        v = 5'd0;
        l = 5'd0;
        for (int i = 0; i < 5; i++) begin
            if (qd[i].size() > 0) begin
                v[i] = 1'b1;
                f[i] = qd[i][0];
                l[i] = ql[i][0];
            end
        end
        bus.in_flits = f;
        bus.in_valid = v;
        bus.in_last  = l;
    endtask

    // One clock: upstream retires popped flits, drives, then outputs are scored at negedge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (pop_seen[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
            end
        end
        drive_inputs();
        bus.credit_return = cr_req | (auto_ret & prev_ov);
        cr_req = 1'b0;
        @(negedge clk);
        tick_no++;
        pop_seen = bus.in_pop;
        prev_ov  = bus.out_valid;
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check_value("unexpected_out", DW'(bus.out_valid), DW'(0));
            end else begin
                e = sb.pop_front();
                check_value("out_flit", bus.out_flit, e.data);
                check_value("in_pop", DW'(bus.in_pop), DW'(e.pop));
                check_value("locked", DW'(bus.locked), DW'(e.lk));
                check_value("lock_owner", DW'(bus.lock_owner), DW'(e.own));
                if (e.gap >= 0) check_value("gap", DW'(tick_no - last_out_tick), DW'(e.gap));
            end
            last_out_tick = tick_no;
        end
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_value("drain", DW'(sb.size()), DW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_out_valid"}, DW'(bus.out_valid), DW'(0));
        check_value({tag, "_in_pop"}, DW'(bus.in_pop), DW'(0));
        check_value({tag, "_locked"}, DW'(bus.locked), DW'(0));
        check_value({tag, "_owner"}, DW'(bus.lock_owner), DW'(0));
        check_value({tag, "_credits"}, DW'(bus.credits), DW'(CR));
        check_value({tag, "_err"}, DW'(bus.credit_err), DW'(0));
        check_value({tag, "_out_flit"}, bus.out_flit, DW'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
        sb.delete();
        pop_seen = 5'd0;
        prev_ov  = 1'b0;
        cr_req   = 1'b0;
        bus.in_valid      = 5'd0;
        bus.in_flits      = '0;
        bus.in_last       = 5'd0;
        bus.credit_return = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] d5;

        // Single-flit packets on all five inputs: strict 0..4 rotation, one per cycle
        do_reset();
        auto_ret = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 5; p++)
                add_flit(p, 1'b1, 1'b1, 1'b0, 3'd0, (r == 0 && p == 0) ? -1 : 1, d);
        run_until_empty(20);
        repeat (3) tick();
        check_value("t1_credits_restored", DW'(bus.credits), DW'(CR));

        // 3-flit packet on input 2 holds the link while input 0 waits
        do_reset();
        add_flit(1, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        run_until_empty(10);
        add_flit(2, 1'b0, 1'b1, 1'b1, 3'd2, -1, d);
        add_flit(2, 1'b0, 1'b1, 1'b1, 3'd2, 2, d);
        add_flit(2, 1'b1, 1'b1, 1'b0, 3'd0, 2, d);
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, 2, d);
        run_until_empty(20);
        repeat (2) tick();

        // Credit exhaustion: four sends then stall; one return releases exactly one more
        do_reset();
        auto_ret = 1'b0;
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        add_flit(1, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        add_flit(1, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        add_flit(0, 1'b1, 1'b0, 1'b0, 3'd0, -1, d5);
        add_flit(1, 1'b1, 1'b0, 1'b0, 3'd0, -1, d);
        add_flit(0, 1'b1, 1'b0, 1'b0, 3'd0, -1, d);
        add_flit(1, 1'b1, 1'b0, 1'b0, 3'd0, -1, d);
        repeat (8) tick();
        check_value("t3_four_sends", DW'(sb.size()), DW'(0));
        check_value("t3_credits_zero", DW'(bus.credits), DW'(0));
        check_value("t3_stalled", DW'(bus.out_valid), DW'(0));
        cr_req = 1'b1;
        tick();
        pulse_tick = tick_no;
        push_exp(d5, 0, 1'b0, 3'd0, -1);
        tick();
        tick();
        check_value("t3_send_after_return", DW'(last_out_tick), DW'(pulse_tick + 2));
        check_value("t3_one_more", DW'(sb.size()), DW'(0));
        repeat (4) tick();
        check_value("t3_credits_zero_again", DW'(bus.credits), DW'(0));

        // Send and credit return in the same cycle at credits=2
        do_reset();
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        add_flit(1, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        add_flit(0, 1'b1, 1'b1, 1'b0, 3'd0, 1, d);
        tick();
        tick();
        check_value("t4_credits_3", DW'(bus.credits), DW'(3));
        cr_req = 1'b1;
        tick();
        check_value("t4_credits_2", DW'(bus.credits), DW'(2));
        tick();
        check_value("t4_send_and_return", DW'(bus.credits), DW'(2));
        tick();
        check_value("t4_hold", DW'(bus.credits), DW'(2));
        check_value("t4_drain", DW'(sb.size()), DW'(0));

        // Credit return while already full is flagged and sticky
        do_reset();
        cr_req = 1'b1;
        tick();
        tick();
        check_value("t5_credits_full", DW'(bus.credits), DW'(CR));
        check_value("t5_err_set", DW'(bus.credit_err), DW'(1));
        add_flit(3, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        run_until_empty(10);
        repeat (3) tick();
        check_value("t5_err_sticky", DW'(bus.credit_err), DW'(1));

        // Asynchronous reset mid-packet, then arbitration restarts from port 0
        do_reset();
        auto_ret = 1'b1;
        add_flit(2, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        add_flit(3, 1'b0, 1'b1, 1'b1, 3'd3, 1, d);
        add_flit(3, 1'b0, 1'b0, 1'b0, 3'd0, -1, d);
        add_flit(3, 1'b1, 1'b0, 1'b0, 3'd0, -1, d);
        run_until_empty(10);
        check_value("t6_locked_before", DW'(bus.locked), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        do_reset();
        add_flit(4, 1'b1, 1'b0, 1'b0, 3'd0, -1, d5);
        add_flit(2, 1'b1, 1'b1, 1'b0, 3'd0, -1, d);
        push_exp(d5, 4, 1'b0, 3'd0, 1);
        run_until_empty(10);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
